sd_bd_dispatch: RTL and testbench



---
 rtl/sd_bd_dispatch_pkg.sv | 28 ++
 rtl/sd_dispatch_wdog.sv | 31 +++
 rtl/sd_bd_dispatch.sv | 133 +++++++++++++
 tb/tb_sd_bd_dispatch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_bd_dispatch_pkg.sv
// Shared definitions for the SD buffer-descriptor dispatch stage:
// FSM state encodings, error codes and default sizing.
package sd_bd_dispatch_pkg;

    localparam int BD_WIDTH_DEF  = 8;
    localparam int BD_SLOTS_DEF  = 8;
    localparam int TIMEOUT_W_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_LATCH    = 4'd2,
        ST_CMD      = 4'd3,
        ST_WAIT_CMD = 4'd4,
        ST_DAT      = 4'd5,
        ST_WAIT_DAT = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CMD  = 2'b01,
        ERR_DAT  = 2'b10,
        ERR_WDOG = 2'b11
    } err_code_t;

endpackage

// File: rtl/sd_dispatch_wdog.sv
// Watchdog for the dispatch FSM wait states: counts while enabled, clears on
// request, flags expiry in the cycle the count reaches TIMEOUT.
module sd_dispatch_wdog #(
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Expiry is flagged during the TIMEOUT-th enabled cycle so the FSM leaves on that edge.
    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT - 1'b1;

    logic [TIMEOUT_W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/sd_bd_dispatch.sv
// Descriptor consumer: pops one buffer descriptor, runs the SD command and the
// data/DMA transfer for it, then retires the slot with a single a_cmp pulse.
module sd_bd_dispatch
    import sd_bd_dispatch_pkg::*;
#(
    parameter int                   BD_WIDTH  = BD_WIDTH_DEF,
    parameter int                   BD_SLOTS  = BD_SLOTS_DEF,
    parameter int                   TIMEOUT_W = TIMEOUT_W_DEF,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [BD_WIDTH-1:0] free_bd,
    output logic                re_s,
    input  logic                ack_i_s,
    input  logic [31:0]         dat_in_s,
    input  logic [31:0]         arg_in_s,
    output logic                a_cmp,
    output logic                cmd_start,
    output logic [31:0]         cmd_arg,
    input  logic                cmd_done,
    input  logic                cmd_err,
    output logic                dat_start,
    output logic [31:0]         dma_addr,
    input  logic                dat_done,
    input  logic                dat_err,
    output logic                busy,
    output logic                err,
    output logic [1:0]          err_code
);

    localparam logic [BD_WIDTH-1:0] SLOTS = BD_WIDTH'(BD_SLOTS);

    state_t    state, state_next;
    err_code_t code_next, code_q;
    logic      err_entry_q;
    logic      pending;
    logic      wdog_clear, wdog_enable, wdog_expired;

    // A free count above the slot total means nothing is queued, never a wrapped pending count.
    assign pending = (free_bd < SLOTS);

    assign wdog_enable = (state == ST_LATCH) || (state == ST_WAIT_CMD) || (state == ST_WAIT_DAT);
    assign wdog_clear  = (state_next != state);

    sd_dispatch_wdog #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .expired (wdog_expired)
    );

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_next = state;
        code_next  = ERR_NONE;
        case (state)
            ST_IDLE:     if (en && !err && pending) state_next = ST_FETCH;
            ST_FETCH:    state_next = ST_LATCH;
            ST_LATCH: begin
                if (ack_i_s) begin
                    state_next = ST_CMD;
                end else if (wdog_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_WDOG;
                end
            end
            ST_CMD:      state_next = ST_WAIT_CMD;
            ST_WAIT_CMD: begin
                if (cmd_done) begin
                    state_next = cmd_err ? ST_ERROR : ST_DAT;
                    code_next  = cmd_err ? ERR_CMD : ERR_NONE;
                end else if (wdog_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_WDOG;
                end
            end
            ST_DAT:      state_next = ST_WAIT_DAT;
            ST_WAIT_DAT: begin
                if (dat_done) begin
                    state_next = dat_err ? ST_ERROR : ST_DONE;
                    code_next  = dat_err ? ERR_DAT : ERR_NONE;
                end else if (wdog_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_WDOG;
                end
            end
            ST_DONE:     state_next = ST_IDLE;
            ST_ERROR:    if (!en) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            err_entry_q <= 1'b0;
            err         <= 1'b0;
            code_q      <= ERR_NONE;
            cmd_arg     <= '0;
            dma_addr    <= '0;
        end else begin
            state       <= state_next;
            err_entry_q <= (state_next == ST_ERROR) && (state != ST_ERROR);
            if ((state_next == ST_ERROR) && (state != ST_ERROR)) begin
                err    <= 1'b1;
                code_q <= code_next;
            end else if ((state == ST_ERROR) && (state_next == ST_IDLE)) begin
                err    <= 1'b0;
                code_q <= ERR_NONE;
            end
            if ((state == ST_LATCH) && ack_i_s) begin
                dma_addr <= dat_in_s;
                cmd_arg  <= arg_in_s;
            end
        end
    end

    // The error path retires the slot too, so the FIFO never stalls on a failed descriptor.
    assign a_cmp     = (state == ST_DONE) || err_entry_q;
    assign re_s      = (state == ST_FETCH);
    assign cmd_start = (state == ST_CMD);
    assign dat_start = (state == ST_DAT);
    assign busy      = (state != ST_IDLE);
    assign err_code  = code_q;

endmodule

// File: tb/tb_sd_bd_dispatch.sv
// Directed self-checking bench for sd_bd_dispatch, with the watchdog shortened
// to 16 cycles so the timeout paths are reachable.
module tb_sd_bd_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  free_bd = 8'd8;
    logic        re_s;
    logic        ack_i_s = 1'b0;
    logic [31:0] dat_in_s = 32'h0;
    logic [31:0] arg_in_s = 32'h0;
    logic        a_cmp;
    logic        cmd_start;
    logic [31:0] cmd_arg;
    logic        cmd_done = 1'b0;
    logic        cmd_err = 1'b0;
    logic        dat_start;
    logic [31:0] dma_addr;
    logic        dat_done = 1'b0;
    logic        dat_err = 1'b0;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int n_re = 0, n_acmp = 0, n_cmd_start = 0, n_dat_start = 0;
    int base_re, base_acmp, base_dat;

    sd_bd_dispatch #(
        .BD_WIDTH  (8),
        .BD_SLOTS  (8),
        .TIMEOUT_W (16),
        .TIMEOUT   (16'd16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .free_bd   (free_bd),
        .re_s      (re_s),
        .ack_i_s   (ack_i_s),
        .dat_in_s  (dat_in_s),
        .arg_in_s  (arg_in_s),
        .a_cmp     (a_cmp),
        .cmd_start (cmd_start),
        .cmd_arg   (cmd_arg),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err),
        .dat_start (dat_start),
        .dma_addr  (dma_addr),
        .dat_done  (dat_done),
        .dat_err   (dat_err),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (re_s)      n_re++;
        if (a_cmp)     n_acmp++;
        if (cmd_start) n_cmd_start++;
        if (dat_start) n_dat_start++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From IDLE with one descriptor queued, walk to the first WAIT_CMD cycle.
    task automatic to_wait_cmd(input logic [31:0] d, input logic [31:0] a);
        free_bd = 8'd7;
        tick();                                   // FETCH
        tick();                                   // LATCH
        ack_i_s = 1'b1; dat_in_s = d; arg_in_s = a;
        tick();                                   // CMD
        ack_i_s = 1'b0; dat_in_s = 32'hDEAD_BEEF; arg_in_s = 32'hDEAD_BEEF;
        tick();                                   // WAIT_CMD
    endtask

    // Serve one descriptor end to end, acting as FIFO and both masters.
    task automatic serve(input string tag, input logic [31:0] d, input logic [31:0] a);
        int n = 0;
        while (!re_s && n < 10) begin
            tick();
            n++;
        end
        check({tag, " re_s"}, re_s, 1);
        check({tag, " fetch latency"}, n, 1);
        tick();                                   // LATCH
        check({tag, " re_s one cycle"}, re_s, 0);
        ack_i_s = 1'b1; dat_in_s = d; arg_in_s = a;
        tick();                                   // CMD
        ack_i_s = 1'b0; dat_in_s = 32'hDEAD_BEEF; arg_in_s = 32'hDEAD_BEEF;
        check({tag, " cmd_start"}, cmd_start, 1);
        check({tag, " cmd_arg"}, cmd_arg, a);
        tick();                                   // WAIT_CMD
        cmd_done = 1'b1;
        tick();                                   // DAT
        cmd_done = 1'b0;
        check({tag, " dat_start"}, dat_start, 1);
        check({tag, " dma_addr"}, dma_addr, d);
        tick();                                   // WAIT_DAT
        dat_done = 1'b1;
        tick();                                   // DONE
        dat_done = 1'b0;
        check({tag, " a_cmp"}, a_cmp, 1);
        tick();                                   // IDLE; FIFO sees the retire on this edge
        free_bd = free_bd + 8'd1;
        check({tag, " a_cmp low"}, a_cmp, 0);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst re_s", re_s, 0);
        check("rst a_cmp", a_cmp, 0);
        check("rst cmd_start", cmd_start, 0);
        check("rst dat_start", dat_start, 0);
        check("rst cmd_arg", cmd_arg, 0);
        check("rst dma_addr", dma_addr, 0);
        check("rst err", err, 0);
        check("rst err_code", err_code, 0);
        rst = 1'b0;
        en  = 1'b1;
        tick();
        check("idle no pending", re_s, 0);

        // Single descriptor
        base_re = n_re; base_acmp = n_acmp;
        free_bd = 8'd7;
        serve("single", 32'h1000, 32'h20);
        check("single busy after", busy, 0);
        tick();
        tick();
        check("single no refetch", re_s, 0);
        check("single re count", n_re - base_re, 1);
        check("single a_cmp count", n_acmp - base_acmp, 1);

        // Three queued descriptors
        base_re = n_re; base_acmp = n_acmp;
        free_bd = 8'd5;
        serve("q0", 32'h0000_2000, 32'h0000_0100);
        serve("q1", 32'h0000_3000, 32'h0000_0101);
        serve("q2", 32'h0000_4000, 32'h0000_0102);
        check("queue free_bd", free_bd, 8);
        tick();
        tick();
        tick();
        check("queue idle", busy, 0);
        check("queue re count", n_re - base_re, 3);
        check("queue a_cmp count", n_acmp - base_acmp, 3);

        // Free count above slot total means nothing pending
        free_bd = 8'd9;
        tick();
        tick();
        check("overfull no fetch", re_s, 0);
        check("overfull idle", busy, 0);

        // Command error
        base_dat = n_dat_start; base_acmp = n_acmp;
        to_wait_cmd(32'h5000, 32'h55);
        cmd_done = 1'b1; cmd_err = 1'b1;
        tick();                                   // ERROR
        cmd_done = 1'b0; cmd_err = 1'b0;
        check("cmd_err err", err, 1);
        check("cmd_err code", err_code, 2'b01);
        check("cmd_err a_cmp", a_cmp, 1);
        tick();
        free_bd = 8'd8;
        check("cmd_err a_cmp once", a_cmp, 0);
        check("cmd_err held", busy, 1);
        en = 1'b0;
        tick();                                   // IDLE
        check("cmd_err cleared", err, 0);
        check("cmd_err code cleared", err_code, 0);
        check("cmd_err idle", busy, 0);
        check("cmd_err no dat_start", n_dat_start - base_dat, 0);
        check("cmd_err a_cmp count", n_acmp - base_acmp, 1);
        en = 1'b1;

        // Data error
        base_acmp = n_acmp;
        to_wait_cmd(32'h6000, 32'h66);
        cmd_done = 1'b1;
        tick();                                   // DAT
        cmd_done = 1'b0;
        tick();                                   // WAIT_DAT
        dat_done = 1'b1; dat_err = 1'b1;
        tick();                                   // ERROR
        dat_done = 1'b0; dat_err = 1'b0;
        check("dat_err code", err_code, 2'b10);
        check("dat_err a_cmp", a_cmp, 1);
        tick();
        free_bd = 8'd8;
        tick();
        tick();
        check("dat_err sticky", err, 1);
        check("dat_err stays", busy, 1);
        check("dat_err a_cmp count", n_acmp - base_acmp, 1);
        en = 1'b0;
        tick();
        check("dat_err cleared", err, 0);
        en = 1'b1;

        // Watchdog on WAIT_CMD: expiry in the 16th cycle
        to_wait_cmd(32'h7000, 32'h77);
        repeat (15) tick();
        check("wdog not yet", err, 0);
        check("wdog still waiting", busy, 1);
        tick();
        check("wdog err", err, 1);
        check("wdog code", err_code, 2'b11);
        check("wdog a_cmp", a_cmp, 1);
        free_bd = 8'd8;
        en = 1'b0;
        tick();
        tick();
        check("wdog cleared", err, 0);
        en = 1'b1;

        // dat_done in the same cycle as expiry: done wins
        to_wait_cmd(32'h8000, 32'h88);
        cmd_done = 1'b1;
        tick();                                   // DAT
        cmd_done = 1'b0;
        tick();                                   // WAIT_DAT cycle 1
        repeat (15) tick();                       // cycle 16
        dat_done = 1'b1;
        tick();                                   // DONE
        dat_done = 1'b0;
        check("race a_cmp", a_cmp, 1);
        check("race no err", err, 0);
        tick();
        free_bd = 8'd8;
        check("race idle", busy, 0);

        // Reset during WAIT_DAT
        to_wait_cmd(32'h9000, 32'h99);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();                                   // WAIT_DAT
        base_acmp = n_acmp;
        rst = 1'b1;
        tick();
        check("mid rst busy", busy, 0);
        check("mid rst a_cmp", a_cmp, 0);
        check("mid rst cmd_arg", cmd_arg, 0);
        check("mid rst dma_addr", dma_addr, 0);
        check("mid rst err", err, 0);
        check("mid rst dat_start", dat_start, 0);
        rst = 1'b0;
        en = 1'b0;
        free_bd = 8'd8;
        tick();
        tick();
        check("mid rst no a_cmp", n_acmp - base_acmp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
